calendar_counter: RTL and testbench

//   Free-running wall-clock calendar: divides clk down to a 1 Hz tick and keeps

---
 rtl/calendar_pkg.sv | 45 ++++
 rtl/tick_gen.sv | 30 +++
 rtl/calendar_counter.sv | 150 +++++++++++++++
 tb/tb_calendar_counter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Purpose: shared calendar field widths, reset date and Gregorian helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Used by calendar_counter, the timestamp converter and the UI set logic.
package calendar_pkg;

  localparam int YEAR_W   = 14;
  localparam int MONTH_W  = 4;
  localparam int DAY_W    = 5;
  localparam int HOUR_W   = 5;
  localparam int MINUTE_W = 6;
  localparam int SECOND_W = 6;

  // Reset/wrap date apart from the year, which is the YEAR_MIN parameter.
  localparam logic [MONTH_W-1:0]  RST_MONTH  = 4'd1;
  localparam logic [DAY_W-1:0]    RST_DAY    = 5'd1;
  localparam logic [HOUR_W-1:0]   RST_HOUR   = 5'd0;
  localparam logic [MINUTE_W-1:0] RST_MINUTE = 6'd0;
  localparam logic [SECOND_W-1:0] RST_SECOND = 6'd0;

  typedef struct packed {
    logic [YEAR_W-1:0]   year;
    logic [MONTH_W-1:0]  month;
    logic [DAY_W-1:0]    day;
    logic [HOUR_W-1:0]   hour;
    logic [MINUTE_W-1:0] minute;
    logic [SECOND_W-1:0] second;
  } cal_t;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    return (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0)) ||
           ((y % 14'd400) == 14'd0);
  endfunction

  // Out-of-range months return 31; callers range-check the month separately.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] m,
                                                     input logic [YEAR_W-1:0]  y);
    case (m)
      4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Purpose: prescaler counting 0..CLK_FREQ_HZ-1; flags the cycle whose edge wraps it.
// Latency: wrap is combinational from the counter; counter clears on the edge after clr.
// Backpressure: none; free-running.
// Ports: clk, rst (sync, active-high), clr (restart phase), wrap (high in last count).
module tick_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic wrap
);

  localparam int            CW   = $clog2(CLK_FREQ_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = cnt_q + 1'b1;
    if (clr || wrap) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/calendar_counter.sv
// Purpose: free-running Gregorian wall-clock calendar with validated set command.
// Latency: fields/sec_tick/set_err update one edge after the wrap or set_valid sample.
// Backpressure: none; set_valid always accepted, illegal requests answered with set_err.
// Ports: clk, rst (sync, active-high); set_valid + set_{year..second} in;
//   set_err, sec_tick, year, month, day, hour, minute, second out.
// Optional macro ALARM_EN adds alarm_en, alarm_hour, alarm_minute in and alarm_hit out.
module calendar_counter
  import calendar_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int YEAR_MIN    = 1970,
  parameter int YEAR_MAX    = 9999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_valid,
  input  logic [YEAR_W-1:0]   set_year,
  input  logic [MONTH_W-1:0]  set_month,
  input  logic [DAY_W-1:0]    set_day,
  input  logic [HOUR_W-1:0]   set_hour,
  input  logic [MINUTE_W-1:0] set_minute,
  input  logic [SECOND_W-1:0] set_second,
  output logic                set_err,
  output logic                sec_tick,
  output logic [YEAR_W-1:0]   year,
  output logic [MONTH_W-1:0]  month,
  output logic [DAY_W-1:0]    day,
  output logic [HOUR_W-1:0]   hour,
  output logic [MINUTE_W-1:0] minute,
  output logic [SECOND_W-1:0] second
`ifdef ALARM_EN
  ,
  input  logic                alarm_en,
  input  logic [HOUR_W-1:0]   alarm_hour,
  input  logic [MINUTE_W-1:0] alarm_minute,
  output logic                alarm_hit
`endif
);

  localparam logic [YEAR_W-1:0] YMIN = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

  cal_t cur_q, cur_d, inc, set_v;
  logic tick_q, tick_d, err_q, err_d;
  logic wrap, set_ok;

  tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (set_ok),
    .wrap (wrap)
  );

  always_comb begin
    set_v  = {set_year, set_month, set_day, set_hour, set_minute, set_second};
    set_ok = set_valid &&
             (set_year >= YMIN) && (set_year <= YMAX) &&
             (set_month >= 4'd1) && (set_month <= 4'd12) &&
             (set_day >= 5'd1) && (set_day <= days_in_month(set_month, set_year)) &&
             (set_hour < 5'd24) && (set_minute < 6'd60) && (set_second < 6'd60);
  end

  // Full carry chain resolved in a single cycle.
  always_comb begin
    inc = cur_q;
    if (cur_q.second != 6'd59) begin
      inc.second = cur_q.second + 6'd1;
    end else begin
      inc.second = '0;
      if (cur_q.minute != 6'd59) begin
        inc.minute = cur_q.minute + 6'd1;
      end else begin
        inc.minute = '0;
        if (cur_q.hour != 5'd23) begin
          inc.hour = cur_q.hour + 5'd1;
        end else begin
          inc.hour = '0;
          if (cur_q.day != days_in_month(cur_q.month, cur_q.year)) begin
            inc.day = cur_q.day + 5'd1;
          end else begin
            inc.day = 5'd1;
            if (cur_q.month != 4'd12) begin
              inc.month = cur_q.month + 4'd1;
            end else begin
              inc.month = 4'd1;
              inc.year  = (cur_q.year == YMAX) ? YMIN : cur_q.year + 14'd1;
            end
          end
        end
      end
    end
  end

  // A legal set overrides a coincident wrap and the tick is dropped;
  // an illegal set leaves the normal advance untouched.
  always_comb begin
    cur_d  = cur_q;
    tick_d = 1'b0;
    err_d  = 1'b0;
    if (set_ok) begin
      cur_d = set_v;
    end else begin
      err_d = set_valid;
      if (wrap) begin
        cur_d  = inc;
        tick_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= {YMIN, RST_MONTH, RST_DAY, RST_HOUR, RST_MINUTE, RST_SECOND};
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

`ifdef ALARM_EN
  logic hit_q, hit_d;

  // Only a genuine advance onto hh:mm:00 fires; a set landing there does not.
  always_comb begin
    hit_d = !set_ok && wrap && alarm_en &&
            (inc.hour == alarm_hour) && (inc.minute == alarm_minute) &&
            (inc.second == 6'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit_d;
  end

  assign alarm_hit = hit_q;
`endif

  assign set_err  = err_q;
  assign sec_tick = tick_q;
  assign year     = cur_q.year;
  assign month    = cur_q.month;
  assign day      = cur_q.day;
  assign hour     = cur_q.hour;
  assign minute   = cur_q.minute;
  assign second   = cur_q.second;

endmodule

// File: tb/tb_calendar_counter.sv
// Purpose: self-checking bench for calendar_counter with CLK_FREQ_HZ=4.
// Latency: n/a.
// Backpressure: n/a. Alarm checks are compiled in when ALARM_EN is defined.
module tb_calendar_counter;

  localparam int F    = 4;
  localparam int YMIN = 1970;
  localparam int YMAX = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_valid = 1'b0;
  logic [13:0] set_year = '0;
  logic [3:0]  set_month = '0;
  logic [4:0]  set_day = '0;
  logic [4:0]  set_hour = '0;
  logic [5:0]  set_minute = '0;
  logic [5:0]  set_second = '0;
  logic        set_err, sec_tick;
  logic [13:0] year;
  logic [3:0]  month;
  logic [4:0]  day;
  logic [4:0]  hour;
  logic [5:0]  minute;
  logic [5:0]  second;
`ifdef ALARM_EN
  logic        alarm_en = 1'b0;
  logic [4:0]  alarm_hour = '0;
  logic [5:0]  alarm_minute = '0;
  logic        alarm_hit;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calendar_counter #(.CLK_FREQ_HZ(F), .YEAR_MIN(YMIN), .YEAR_MAX(YMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .set_valid  (set_valid),
    .set_year   (set_year),
    .set_month  (set_month),
    .set_day    (set_day),
    .set_hour   (set_hour),
    .set_minute (set_minute),
    .set_second (set_second),
    .set_err    (set_err),
    .sec_tick   (sec_tick),
    .year       (year),
    .month      (month),
    .day        (day),
    .hour       (hour),
    .minute     (minute),
    .second     (second)
`ifdef ALARM_EN
    ,
    .alarm_en     (alarm_en),
    .alarm_hour   (alarm_hour),
    .alarm_minute (alarm_minute),
    .alarm_hit    (alarm_hit)
`endif
  );

  // ---------------- reference model (calendar arithmetic on integers) ----------------
  int m_y = YMIN, m_mo = 1, m_d = 1, m_h = 0, m_mi = 0, m_s = 0, m_phase = 0;
  bit m_tick = 0, m_err = 0, m_hit = 0;

  function automatic bit leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int mdays(input int mo, input int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo < 1 || mo > 12) return 0;
    return t[mo-1] + ((mo == 2 && leap(y)) ? 1 : 0);
  endfunction

  function automatic bit legal(input int y, input int mo, input int d,
                               input int h, input int mi, input int s);
    return (y >= YMIN) && (y <= YMAX) && (mo >= 1) && (mo <= 12) &&
           (d >= 1) && (d <= mdays(mo, y)) && (h < 24) && (mi < 60) && (s < 60);
  endfunction

  function automatic logic [39:0] pk(input int y, input int mo, input int d,
                                     input int h, input int mi, input int s);
    return {y[13:0], mo[3:0], d[4:0], h[4:0], mi[5:0], s[5:0]};
  endfunction

  logic [39:0] dut_now, model_now;
  assign dut_now   = {year, month, day, hour, minute, second};
  assign model_now = pk(m_y, m_mo, m_d, m_h, m_mi, m_s);

  always @(posedge clk) begin : model
    int sod;
    m_tick = 0;
    m_err  = 0;
    m_hit  = 0;
    if (rst) begin
      m_y = YMIN; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0; m_phase = 0;
    end else if (set_valid && legal(int'(set_year), int'(set_month), int'(set_day),
                                    int'(set_hour), int'(set_minute), int'(set_second))) begin
      m_y = int'(set_year); m_mo = int'(set_month); m_d = int'(set_day);
      m_h = int'(set_hour); m_mi = int'(set_minute); m_s = int'(set_second);
      m_phase = 0;
    end else begin
      m_err = set_valid;
      m_phase = m_phase + 1;
      if (m_phase == F) begin
        m_phase = 0;
        m_tick  = 1;
        sod = m_h * 3600 + m_mi * 60 + m_s + 1;
        if (sod == 86400) begin
          sod = 0;
          m_d = m_d + 1;
          if (m_d > mdays(m_mo, m_y)) begin
            m_d = 1;
            m_mo = m_mo + 1;
            if (m_mo > 12) begin
              m_mo = 1;
              m_y = (m_y == YMAX) ? YMIN : m_y + 1;
            end
          end
        end
        m_h  = sod / 3600;
        m_mi = (sod / 60) % 60;
        m_s  = sod % 60;
`ifdef ALARM_EN
        m_hit = alarm_en && (m_h == int'(alarm_hour)) && (m_mi == int'(alarm_minute)) && (m_s == 0);
`endif
      end
    end
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  typedef struct { int y, mo, d, ey, emo, ed; } dcase_t;
  typedef struct { int y, mo, d, h, mi, s; }    tcase_t;

  // Called at a negedge; returns at the negedge after the request was sampled.
  task automatic drive_set(input int y, input int mo, input int d,
                           input int h, input int mi, input int s);
    set_valid  = 1'b1;
    set_year   = 14'(y);
    set_month  = 4'(mo);
    set_day    = 5'(d);
    set_hour   = 5'(h);
    set_minute = 6'(mi);
    set_second = 6'(s);
    @(negedge clk);
    set_valid  = 1'b0;
  endtask

  task automatic wait_tick(output bit ok, output int n);
    ok = 0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (sec_tick === 1'b1) ok = 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ok; int n;
    rst = 1'b1;
    drive_set(2024, 6, 15, 12, 0, 0);  // set_valid alongside rst must be ignored
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
    checks++; if (dut_now !== pk(1970, 1, 1, 0, 0, 0)) begin errors++;
      $display("FAIL reset_fields: got %h want %h", dut_now, pk(1970, 1, 1, 0, 0, 0)); end
    checks++; if (sec_tick !== 1'b0 || set_err !== 1'b0) begin errors++;
      $display("FAIL reset_pulses: got tick=%b err=%b want 0 0", sec_tick, set_err); end
    rst = 1'b0;
    wait_tick(ok, n);
    checks++; if (!ok || n != 4) begin errors++;
      $display("FAIL first_tick: got %0d cycles (seen=%0d) want 4", n, ok); end
    checks++; if (dut_now !== pk(1970, 1, 1, 0, 0, 1)) begin errors++;
      $display("FAIL first_tick_time: got %h want %h", dut_now, pk(1970, 1, 1, 0, 0, 1)); end
    wait_tick(ok, n);
    checks++; if (!ok || n != 4 || second !== 6'd2) begin errors++;
      $display("FAIL second_tick: got %0d cycles second=%0d want 4 cycles second=2", n, second); end
  endtask

  task automatic run_date_cases(input string tag, input dcase_t c[]);
    bit ok; int n;
    foreach (c[i]) begin
      drive_set(c[i].y, c[i].mo, c[i].d, 23, 59, 59);
      checks++; if (dut_now !== pk(c[i].y, c[i].mo, c[i].d, 23, 59, 59) || sec_tick !== 1'b0) begin
        errors++;
        $display("FAIL %s_load[%0d]: got %h tick=%b want %h tick=0", tag, i, dut_now, sec_tick,
                 pk(c[i].y, c[i].mo, c[i].d, 23, 59, 59));
      end
      wait_tick(ok, n);
      checks++; if (!ok || n != 4 || dut_now !== pk(c[i].ey, c[i].emo, c[i].ed, 0, 0, 0)) begin
        errors++;
        $display("FAIL %s_next[%0d]: got %h after %0d cycles want %h after 4", tag, i, dut_now, n,
                 pk(c[i].ey, c[i].emo, c[i].ed, 0, 0, 0));
      end
    end
  endtask

  task automatic test_leap();
    dcase_t c[] = '{'{2024, 2, 28, 2024, 2, 29}, '{2023, 2, 28, 2023, 3, 1},
                    '{2000, 2, 28, 2000, 2, 29}, '{2100, 2, 28, 2100, 3, 1},
                    '{2400, 2, 28, 2400, 2, 29}, '{2024, 2, 29, 2024, 3, 1}};
    run_date_cases("leap", c);
  endtask

  task automatic test_rollover();
    dcase_t c[] = '{'{2023, 12, 31, 2024, 1, 1}, '{9999, 12, 31, 1970, 1, 1},
                    '{2023, 4, 30, 2023, 5, 1},  '{2023, 1, 31, 2023, 2, 1}};
    run_date_cases("roll", c);
  endtask

  task automatic test_illegal();
    bit ok; int n;
    tcase_t c[] = '{'{2023, 2, 29, 10, 0, 0}, '{2023, 13, 1, 10, 0, 0},
                    '{2023, 6, 10, 24, 0, 0}, '{1969, 6, 10, 10, 0, 0},
                    '{2023, 4, 31, 0, 0, 0},  '{2023, 6, 0, 0, 0, 0},
                    '{2023, 6, 10, 10, 60, 0}, '{10000, 1, 1, 0, 0, 0}};
    foreach (c[i]) begin
      drive_set(2023, 6, 10, 10, 20, 30);
      drive_set(c[i].y, c[i].mo, c[i].d, c[i].h, c[i].mi, c[i].s);
      checks++; if (set_err !== 1'b1 || sec_tick !== 1'b0 || dut_now !== pk(2023, 6, 10, 10, 20, 30)) begin
        errors++;
        $display("FAIL illegal_reject[%0d]: got err=%b tick=%b %h want err=1 tick=0 %h", i, set_err,
                 sec_tick, dut_now, pk(2023, 6, 10, 10, 20, 30));
      end
      @(negedge clk);
      checks++; if (set_err !== 1'b0) begin errors++;
        $display("FAIL illegal_pulse_width[%0d]: got set_err=%b want 0", i, set_err); end
      wait_tick(ok, n);
      checks++; if (!ok || n != 2 || dut_now !== pk(2023, 6, 10, 10, 20, 31)) begin errors++;
        $display("FAIL illegal_tick_phase[%0d]: got %0d cycles %h want 2 cycles %h", i, n, dut_now,
                 pk(2023, 6, 10, 10, 20, 31));
      end
    end
  endtask

  task automatic test_set_on_wrap();
    bit ok; int n;
    drive_set(2023, 6, 10, 10, 20, 30);
    repeat (3) @(negedge clk);
    drive_set(2022, 1, 1, 5, 6, 7);  // sampled on the wrap edge
    checks++; if (dut_now !== pk(2022, 1, 1, 5, 6, 7) || sec_tick !== 1'b0) begin errors++;
      $display("FAIL wrap_set_wins: got %h tick=%b want %h tick=0", dut_now, sec_tick, pk(2022, 1, 1, 5, 6, 7)); end
    wait_tick(ok, n);
    checks++; if (!ok || n != 4 || dut_now !== pk(2022, 1, 1, 5, 6, 8)) begin errors++;
      $display("FAIL wrap_next_tick: got %0d cycles %h want 4 cycles %h", n, dut_now, pk(2022, 1, 1, 5, 6, 8)); end
    repeat (3) @(negedge clk);
    drive_set(2022, 13, 1, 5, 6, 7);  // illegal on the wrap edge
    checks++; if (set_err !== 1'b1 || sec_tick !== 1'b1 || dut_now !== pk(2022, 1, 1, 5, 6, 9)) begin errors++;
      $display("FAIL wrap_illegal: got err=%b tick=%b %h want err=1 tick=1 %h", set_err, sec_tick, dut_now,
               pk(2022, 1, 1, 5, 6, 9)); end
    rst = 1'b1;
    drive_set(2030, 3, 3, 3, 3, 3);
    rst = 1'b0;
    checks++; if (dut_now !== pk(1970, 1, 1, 0, 0, 0) || sec_tick !== 1'b0 || set_err !== 1'b0) begin errors++;
      $display("FAIL rst_over_set: got %h tick=%b err=%b want %h 0 0", dut_now, sec_tick, set_err,
               pk(1970, 1, 1, 0, 0, 0)); end
    wait_tick(ok, n);
    checks++; if (!ok || n != 4) begin errors++;
      $display("FAIL rst_tick_phase: got %0d cycles want 4", n); end
  endtask

  task automatic test_random();
    int r, y, mo;
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      rst = (r < 2);
      set_valid = (r >= 2 && r < 16);
      if (r % 2 == 0) begin
        y  = ($urandom_range(0, 3) == 0) ? YMAX : int'($urandom_range(1970, 2404));
        mo = int'($urandom_range(1, 12));
        set_year   = 14'(y);
        set_month  = 4'(mo);
        set_day    = 5'(mdays(mo, y) - int'($urandom_range(0, 1)));
        set_hour   = 5'($urandom_range(22, 23));
        set_minute = 6'($urandom_range(58, 59));
        set_second = 6'($urandom_range(56, 59));
      end else begin
        set_year   = 14'($urandom_range(1960, 10010));
        set_month  = 4'($urandom_range(0, 15));
        set_day    = 5'($urandom_range(0, 31));
        set_hour   = 5'($urandom_range(0, 31));
        set_minute = 6'($urandom_range(0, 63));
        set_second = 6'($urandom_range(0, 63));
      end
`ifdef ALARM_EN
      alarm_en     = 1'($urandom_range(0, 1));
      alarm_hour   = hour;
      alarm_minute = 6'($urandom_range(0, 59));
`endif
      @(negedge clk);
      checks++; if (dut_now !== model_now) begin errors++;
        $display("FAIL rand_fields[%0d]: got %h want %h", i, dut_now, model_now); end
      checks++; if (sec_tick !== m_tick || set_err !== m_err) begin errors++;
        $display("FAIL rand_pulses[%0d]: got tick=%b err=%b want tick=%b err=%b", i, sec_tick, set_err,
                 m_tick, m_err); end
`ifdef ALARM_EN
      checks++; if (alarm_hit !== m_hit) begin errors++;
        $display("FAIL rand_alarm[%0d]: got %b want %b", i, alarm_hit, m_hit); end
`endif
    end
    rst = 1'b0;
    set_valid = 1'b0;
  endtask

`ifdef ALARM_EN
  task automatic test_alarm();
    bit ok; int n;
    alarm_hour = 5'd7; alarm_minute = 6'd30; alarm_en = 1'b1;
    drive_set(2023, 6, 10, 7, 29, 59);
    wait_tick(ok, n);
    checks++; if (!ok || alarm_hit !== 1'b1 || dut_now !== pk(2023, 6, 10, 7, 30, 0)) begin errors++;
      $display("FAIL alarm_fire: got hit=%b %h want hit=1 %h", alarm_hit, dut_now, pk(2023, 6, 10, 7, 30, 0)); end
    @(negedge clk);
    checks++; if (alarm_hit !== 1'b0) begin errors++;
      $display("FAIL alarm_width: got %b want 0", alarm_hit); end
    alarm_en = 1'b0;
    drive_set(2023, 6, 10, 7, 29, 59);
    wait_tick(ok, n);
    checks++; if (!ok || alarm_hit !== 1'b0) begin errors++;
      $display("FAIL alarm_disabled: got hit=%b tick_seen=%0d want hit=0", alarm_hit, ok); end
    alarm_en = 1'b1;
    drive_set(2023, 6, 10, 7, 30, 0);
    checks++; if (alarm_hit !== 1'b0) begin errors++;
      $display("FAIL alarm_on_set: got %b want 0", alarm_hit); end
    wait_tick(ok, n);
    checks++; if (!ok || alarm_hit !== 1'b0) begin errors++;
      $display("FAIL alarm_after_set: got %b want 0", alarm_hit); end
    alarm_en = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_leap();
    test_rollover();
    test_illegal();
    test_set_on_wrap();
`ifdef ALARM_EN
    test_alarm();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
